// File: rtl/counter_pkg.sv
// Shared constants for the parametrised up/down counter family.
package counter_pkg;

    // Direction select on the UP input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bound behaviour select on the SAT input.
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage : counter_pkg

// File: rtl/updown_counter_next.sv
// Next-state logic for param_updown_counter: load/clamp, up/down count,
// wrap or saturate at 0..limit, and the matching wrap flag.
module updown_counter_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] limit,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic             ce,
    output logic [WIDTH-1:0] next_q,
    output logic             next_wrap
);

    // One extra bit so q+1 at all-ones and q-1 at zero are both visible
    // (carry / borrow) instead of aliasing back into range.
    logic [WIDTH:0] q_inc;
    logic [WIDTH:0] q_dec;

    // Wide increment/decrement of the current count.
    always_comb begin
        q_inc = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
        q_dec = {1'b0, q} - {{WIDTH{1'b0}}, 1'b1};
    end

    // Priority LOAD > CE; hold otherwise. Wrap flag only on a wrapping count.
    always_comb begin
        next_q    = q;
        next_wrap = 1'b0;
        if (load) begin
            next_q = (d > limit) ? limit : d;
        end else if (ce) begin
            if (up == DIR_UP) begin
                // q+1 <= limit is the same as q < limit, without overflow.
                if (q_inc <= {1'b0, limit}) begin
                    next_q = q_inc[WIDTH-1:0];
                end else if (sat == MODE_SAT) begin
                    next_q = limit;
                end else begin
                    next_q    = '0;
                    next_wrap = 1'b1;
                end
            end else begin
                if (q > limit) begin
                    // Limit was lowered below the count: snap to the new bound.
                    next_q = limit;
                end else if (!q_dec[WIDTH]) begin
                    // No borrow means q was non-zero.
                    next_q = q_dec[WIDTH-1:0];
                end else if (sat == MODE_SAT) begin
                    next_q = '0;
                end else begin
                    next_q    = limit;
                    next_wrap = 1'b1;
                end
            end
        end
    end

endmodule : updown_counter_next

// File: rtl/param_updown_counter.sv
// General-purpose up/down event/timebase counter with async clear,
// synchronous load, runtime modulus, wrap/saturate mode, terminal count
// and a registered wrap pulse. LIMIT = all-ones, SAT=0, UP=1 behaves as
// the legacy free-running up counter. WIDTH is intended for 1..32 and
// RST_VAL must fit within WIDTH bits.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             CE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic             UP,
    input  logic             SAT,
    input  logic [WIDTH-1:0] LIMIT,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             WRAP
);

    logic [WIDTH-1:0] next_q;
    logic             next_wrap;

    updown_counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q         (Q),
        .d         (D),
        .limit     (LIMIT),
        .up        (UP),
        .sat       (SAT),
        .load      (LOAD),
        .ce        (CE),
        .next_q    (next_q),
        .next_wrap (next_wrap)
    );

    // Count register and wrap pulse; CLR forces the reset value at once.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            Q    <= RST_VAL;
            WRAP <= 1'b0;
        end else begin
            Q    <= next_q;
            WRAP <= next_wrap;
        end
    end

    // Terminal count: at/above the bound counting up, at zero counting down.
    always_comb begin
        if (UP == DIR_UP) begin
            TC = (Q >= LIMIT);
        end else begin
            TC = (Q == '0);
        end
    end

endmodule : param_updown_counter

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter at WIDTH=4.
module tb_param_updown_counter;

    logic       C;
    logic       CLR;
    logic       CE;
    logic       LOAD;
    logic [3:0] D;
    logic       UP;
    logic       SAT;
    logic [3:0] LIMIT;
    logic [3:0] Q;
    logic       TC;
    logic       WRAP;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic       load;
        logic       ce;
        logic       up;
        logic       sat;
        logic [3:0] d;
        logic [3:0] limit;
        logic [3:0] q;
        logic       wrap;
        logic       tc;
    } vec_t;

    vec_t vecs[$];

    param_updown_counter #(
        .WIDTH   (4),
        .RST_VAL (4'd0)
    ) dut (
        .C     (C),
        .CLR   (CLR),
        .CE    (CE),
        .LOAD  (LOAD),
        .D     (D),
        .UP    (UP),
        .SAT   (SAT),
        .LIMIT (LIMIT),
        .Q     (Q),
        .TC    (TC),
        .WRAP  (WRAP)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic ld, input logic ce, input logic up, input logic sat,
                                input logic [3:0] d, input logic [3:0] lim,
                                input logic [3:0] q, input logic wrap, input logic tc);
        vec_t v;
        v.load = ld; v.ce = ce; v.up = up; v.sat = sat;
        v.d = d; v.limit = lim; v.q = q; v.wrap = wrap; v.tc = tc;
        return v;
    endfunction

    task automatic drive(input logic ld, input logic ce, input logic up, input logic sat,
                         input logic [3:0] d, input logic [3:0] lim);
        LOAD = ld; CE = ce; UP = up; SAT = sat; D = d; LIMIT = lim;
    endtask

    initial begin
        // Count up, LIMIT=9, wrap mode: 1..9, 0, 1, 2
        for (int k = 1; k <= 9; k++)
            vecs.push_back(mk(0, 1, 1, 0, 0, 9, 4'(k), 0, (k == 9)));
        vecs.push_back(mk(0, 1, 1, 0, 0, 9, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 9, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 9, 2, 0, 0));
        // Count down from 2, saturate: 1, 0, 0, 0
        vecs.push_back(mk(0, 1, 0, 1, 0, 9, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 9, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 9, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 9, 0, 0, 1));
        // Load with clamp beats CE, plain load, hold
        vecs.push_back(mk(1, 1, 1, 0, 13, 9, 9, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 5, 9, 5, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 9, 5, 0, 0));
        // LIMIT lowered below Q at runtime: up wraps, down snaps, up+sat snaps
        vecs.push_back(mk(1, 0, 1, 0, 12, 15, 12, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 6, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 12, 15, 12, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 6, 6, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 12, 15, 12, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 6, 6, 0, 1));
        // LIMIT=0 wrap: WRAP stays high on consecutive edges
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 1));
        // Down wrap from 0 to LIMIT, then normal decrement
        vecs.push_back(mk(0, 1, 0, 0, 0, 9, 9, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 9, 8, 0, 0));
        // Load 0, wrap down, then load clears WRAP
        vecs.push_back(mk(1, 0, 0, 0, 0, 9, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 9, 9, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 3, 9, 3, 0, 0));
        // Legacy free-running range across all-ones
        vecs.push_back(mk(1, 0, 1, 0, 14, 15, 14, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 15, 15, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 15, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 15, 0, 0, 0));
        // Saturate at all-ones
        vecs.push_back(mk(1, 0, 1, 1, 15, 15, 15, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 15, 15, 0, 1));

        // Reset with count enabled: Q must stay at reset value
        CLR = 1'b1;
        drive(0, 1, 1, 0, 0, 15);
        repeat (2) @(posedge C);
        #1;
        check("reset_q", Q, 0);
        check("reset_wrap", WRAP, 0);
        check("reset_tc", TC, 0);
        drive(0, 0, 1, 0, 0, 9);
        @(negedge C);
        CLR = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].load, vecs[i].ce, vecs[i].up, vecs[i].sat, vecs[i].d, vecs[i].limit);
            @(posedge C);
            #1;
            check($sformatf("v%0d_q", i), Q, vecs[i].q);
            check($sformatf("v%0d_wrap", i), WRAP, vecs[i].wrap);
            check($sformatf("v%0d_tc", i), TC, vecs[i].tc);
        end

        // Async clear mid-count at Q=7, between edges
        drive(1, 0, 1, 0, 7, 9);
        @(posedge C);
        #1;
        check("pre_clr_q", Q, 7);
        drive(0, 1, 1, 0, 0, 9);
        #2;
        CLR = 1'b1;
        #1;
        check("async_clr_q", Q, 0);
        check("async_clr_wrap", WRAP, 0);
        @(posedge C);
        #1;
        check("clr_held_q", Q, 0);
        #3;
        CLR = 1'b0;
        @(posedge C);
        #1;
        check("first_after_clr_q", Q, 1);

        // Async clear while WRAP is high
        drive(0, 1, 1, 0, 0, 0);
        @(posedge C);
        #1;
        check("wrap_before_clr", WRAP, 1);
        #2;
        CLR = 1'b1;
        #1;
        check("async_clr_wrap_hi", WRAP, 0);
        check("async_clr_q2", Q, 0);
        #2;
        CLR = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_param_updown_counter
